bidir_bus_master_16: RTL



---
 rtl/bidir_bus_master_16_pkg.sv | 28 ++
 rtl/bidir_bus_master_16_if.sv | 31 +++
 rtl/bidir_bus_master_16.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bidir_bus_master_16_pkg.sv
// Shared definitions for the 16-bit async DSP-style bus initiator.
//   - Phase counter width (CNT_W)
//   - Minimum strobe lengths that the responder can tolerate
//   - State encoding for the access sequencer
package bus_master_pkg;

  localparam int CNT_W = 4;

  // The responder needs three clocks of we_n low to qualify a write, and
  // drives read data one clock after re_n falls.
  localparam int MIN_WR_STROBE = 3;
  localparam int MIN_RD_STROBE = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_TURN   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_STROBE = ST_STROBE,
    S_HOLD   = ST_HOLD,
    S_TURN   = ST_TURN
  } state_e;

endpackage

// File: rtl/bidir_bus_master_16_if.sv
// Internal request/response side of the bus initiator.
//   req_valid/req_ready : request handshake; a request transfers on a clock
//                         edge where both are high. req_write/addr/wdata must
//                         be stable while req_valid is high. The initiator
//                         never queues: req_valid while req_ready is low is
//                         simply not taken.
//   rsp_valid           : one-cycle pulse when an access completes;
//                         rsp_rdata carries read data with it on reads.
//   busy                : initiator is not idle.
// Modports: master = the internal logic issuing requests,
//           slave  = the bus initiator block.
interface bidir_bus_master_16_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/bidir_bus_master_16.sv
// Initiator for the 16-bit async DSP-style bus. Sequences SETUP, STROBE and
// HOLD phases (plus a TURN gap after reads) in xclk cycles.
// Ports:
//   xclk      : master clock
//   reset     : synchronous, active-high reset
//   req_if    : request/response interface (slave modport)
//   cs_n      : bus chip select, active low
//   re_n      : bus read strobe, active low
//   we_n      : bus write strobe, active low
//   ab        : bus address
//   db        : bidirectional bus data, driven only during write accesses
//   state_dbg : current sequencer state
// Every pin is a flop output; nothing on req_* reaches the pins without a
// register in between.
module bidir_bus_master_16
  import bus_master_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = 1,
  parameter int unsigned WR_STROBE_CYC = 4,
  parameter int unsigned RD_STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC      = 1,
  parameter int unsigned TURN_CYC      = 1
) (
  input  logic                        xclk,
  input  logic                        reset,
  bidir_bus_master_16_if.slave        req_if,
  output logic                        cs_n,
  output logic                        re_n,
  output logic                        we_n,
  output logic [7:0]                  ab,
  inout  wire  [15:0]                 db,
  output state_e                      state_dbg
);

  generate
    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
      $error("SETUP_CYC out of range 1..15");
    end
    if (WR_STROBE_CYC < MIN_WR_STROBE || WR_STROBE_CYC > 15) begin : g_bad_wr
      $error("WR_STROBE_CYC out of range 3..15");
    end
    if (RD_STROBE_CYC < MIN_RD_STROBE || RD_STROBE_CYC > 15) begin : g_bad_rd
      $error("RD_STROBE_CYC out of range 3..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
      $error("HOLD_CYC out of range 1..15");
    end
    if (TURN_CYC > 15) begin : g_bad_turn
      $error("TURN_CYC out of range 0..15");
    end
  endgenerate

  // Counter load values: each phase lasts N cycles, so it starts at N-1
  // and the phase ends on the edge where the counter reads 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD  = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [7:0]       ab_q, ab_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             cs_n_q, cs_n_d;
  logic             re_n_q, re_n_d;
  logic             we_n_q, we_n_d;
  logic             drive_db_q, drive_db_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    ab_d        = ab_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cs_n_d      = cs_n_q;
    re_n_d      = re_n_q;
    we_n_d      = we_n_q;
    drive_db_d  = drive_db_q;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_if.req_valid && ready_q) begin
          write_d    = req_if.req_write;
          ab_d       = req_if.req_addr;
          wdata_d    = req_if.req_wdata;
          cs_n_d     = 1'b0;
          drive_db_d = req_if.req_write;
          cnt_d      = SETUP_LD;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          we_n_d  = ~write_q;
          re_n_d  = write_q;
          cnt_d   = write_q ? WR_LD : RD_LD;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          // Sample on the edge that ends the strobe, while re_n is still low
          // and the responder is still driving.
          if (!write_q) rdata_d = db;
          we_n_d  = 1'b1;
          re_n_d  = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          cs_n_d      = 1'b1;
          drive_db_d  = 1'b0;
          // After a read the responder releases db one clock late; the TURN
          // gap keeps a following write from colliding with it.
          if (!write_q && TURN_CYC > 0) begin
            cnt_d   = TURN_LD;
            state_d = S_TURN;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so req_ready is low during reset and rises one edge later.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge xclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      ab_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cs_n_q      <= 1'b1;
      re_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drive_db_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      ab_q        <= ab_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cs_n_q      <= cs_n_d;
      re_n_q      <= re_n_d;
      we_n_q      <= we_n_d;
      drive_db_q  <= drive_db_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign db = drive_db_q ? wdata_q : 16'hzzzz;

  assign cs_n             = cs_n_q;
  assign re_n             = re_n_q;
  assign we_n             = we_n_q;
  assign ab               = ab_q;
  assign req_if.req_ready = ready_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rdata_q;
  assign req_if.busy      = busy_q;
  assign state_dbg        = state_q;

endmodule
